// File: rtl/mem_port2_arbiter.sv
// Round-robin arbiter sharing memory port 2 between the CPU data path and the DMA engine.
// Handshake: a requester raises req and holds req/we/addr/wdata until it sees its one-cycle done pulse.
module mem_port2_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [3:0]        counter;
    logic              last_grant;
    logic              owner_q;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              grant;
    logic              grant_dma;

    assign grant     = cpu_req | dma_req;
    // DMA wins when it asks alone, or on a tie when the CPU held the previous grant
    assign grant_dma = dma_req & (~cpu_req | ~last_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        busy       = 1'b0;
        cpu_done   = 1'b0;
        dma_done   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) next_state = ACCESS;
            end
            ACCESS: begin
                busy   = 1'b1;
                mem_we = lat_we && (counter == 4'd0);
                if (counter == 4'd0) next_state = RESP;
            end
            RESP: begin
                busy       = 1'b1;
                cpu_done   = ~owner_q;
                dma_done   = owner_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter     <= 4'd0;
            last_grant  <= 1'b1;
            owner_q     <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q   <= grant_dma;
                        lat_we    <= grant_dma ? dma_we    : cpu_we;
                        lat_addr  <= grant_dma ? dma_addr  : cpu_addr;
                        lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
                        counter   <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        last_grant <= owner_q;
                        if (!lat_we) begin
                            if (owner_q) dma_rdata_q <= mem_rdata;
                            else         cpu_rdata_q <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data stay on the latched values in IDLE, so the port holds its last access
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign owner     = owner_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dbg_state = state;

endmodule

// File: doc/mem_port2_arbiter.md
Name: mem_port2_arbiter

Overview:
- Shares the memory's read/write data port (port 2) between two requesters: the CPU data path and a DMA/loader engine.
- Each requester issues single-word read or write transactions over a req/done handshake.
- The arbiter grants requesters round-robin, sequences each access over a configurable number of wait cycles, and returns read data in a per-requester register.
- Sits between CPU, DMA and MEMORY in the system top; the port-1 instruction fetch path is untouched.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 1, memory access cycles per transaction (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU transaction request; held until cpu_done
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  input  ADDR_W  CPU byte address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  CPU read data, valid while cpu_done is high and held afterwards
- cpu_done  output  1  one-cycle completion pulse
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_done: same as the cpu_* ports, for DMA
- mem_addr  output  ADDR_W  to memory_address2
- mem_wdata  output  DATA_W  write data to the memory port
- mem_we  output  1  to memory_write_enable2
- mem_rdata  input  DATA_W  combinational read data from the memory port
- busy  output  1  high in ACCESS or RESP
- owner  output  1  current or last grant: 0 = CPU, 1 = DMA

Behaviour:
- Reset (asynchronous, while reset is 0):
  - state = IDLE, counter = 0, last_grant = 1 (DMA), so the CPU wins the first tie.
  - All outputs 0: mem_addr, mem_wdata, mem_we, cpu/dma_rdata, cpu/dma_done, busy, owner.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE; mem_we = 0; mem_addr and mem_wdata hold their last values.
  - Exactly one req: grant that requester.
  - Both reqs: grant the requester opposite to last_grant.
  - On a grant: latch addr, wdata and we into internal registers; set owner; counter <= LATENCY-1; go to ACCESS next edge.
- ACCESS:
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched_we AND (counter == 0), so each write commits exactly once, on the last access edge.
  - counter != 0: decrement.
  - counter == 0: on a read, capture mem_rdata into the owner's rdata register; last_grant <= owner; go to RESP.
- RESP:
  - Owner's done = 1 for exactly this cycle; mem_we = 0; go to IDLE.
  - Requests are not sampled in RESP.
- Timing:
  - A request sampled at IDLE edge N gives done high during cycle N+LATENCY+1.
  - Per-requester issue interval is LATENCY+2 cycles.
  - Back-to-back: a req still high in the IDLE after done starts a new transaction. A requester wanting one transaction drops req in the cycle it observes done.
- The non-owner's rdata and done are never modified during another requester's transaction.
- Write transactions leave rdata unchanged.
- Request inputs (req, we, addr, wdata) changing during ACCESS have no effect; values were latched at grant.
- Fairness: with both reqs held continuously, grants strictly alternate CPU, DMA, CPU, ...
- Reset mid-transaction: the transaction is abandoned; mem_we drops to 0 asynchronously; no done is issued; after reset release the arbiter restarts in IDLE with CPU priority.
- LATENCY is a static parameter. The counter is 4 bits, and values outside 1..15 are unsupported.

Test Plan:
- Reset release, single CPU read, mem[0x10] = 0xDEADBEEF, LATENCY = 1, cpu_req at edge N -> cpu_done high in cycle N+2, cpu_rdata = 0xDEADBEEF, dma_done stays 0, busy high in cycles N+1..N+2.
- DMA write of 0x12345678 to 0x20 with LATENCY = 3 -> mem_we high for exactly one cycle (third ACCESS cycle), mem_addr = 0x20; a later CPU read of 0x20 returns 0x12345678.
- CPU and DMA both request from the first cycle after reset, held for 4 transactions each -> grant order CPU, DMA, CPU, DMA, ...; owner toggles; each done is a single pulse.
- CPU changes cpu_addr from 0x10 to 0x30 during ACCESS with LATENCY = 2 -> mem_addr stays 0x10 and the read returns mem[0x10].
- reset asserted during ACCESS of a DMA write -> mem_we drops immediately, mem[] unchanged, no dma_done; after release a simultaneous CPU+DMA request grants CPU first.
- DMA read completes, then a CPU write -> dma_rdata retains the DMA value; cpu_rdata unchanged by the write.
